// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, LCR bit positions and transmitter state encoding
package uart_pkg;

    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_COUNTER_W = 5;
    localparam int DATA_W         = 8;

    // Line control register bit positions
    localparam int LC_BITS = 0;  // [1:0] word length select
    localparam int LC_SB   = 2;  // extra stop time
    localparam int LC_PE   = 3;  // parity enable
    localparam int LC_EP   = 4;  // even parity select
    localparam int LC_SP   = 5;  // stick parity
    localparam int LC_BC   = 6;  // break control

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_POP_BYTE    = 3'd1,
        S_SEND_START  = 3'd2,
        S_SEND_BYTE   = 3'd3,
        S_SEND_PARITY = 3'd4,
        S_SEND_STOP   = 3'd5
    } tx_state_e;

    // Last tick index of the stop phase: 16, 24 (1.5 stop at 5 bits) or 32 ticks
    function automatic logic [4:0] stop_last_tick(input logic sb, input logic [1:0] wl);
        if (!sb)
            return 5'd15;
        else if (wl == 2'b00)
            return 5'd23;
        else
            return 5'd31;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// rtl/uart_tx_engine_if.sv - register-block to transmitter signal bundle
// Ports (signals): lcr, tf_push, wb_dat_i, enable, tx_reset, lsr_mask driven by the
// register block (master); stx_pad_o, tstate, tf_count returned by the engine (slave).
interface uart_tx_engine_if;
    import uart_pkg::*;

    logic [7:0]                lcr;
    logic                      tf_push;
    logic [DATA_W-1:0]         wb_dat_i;
    logic                      enable;
    logic                      tx_reset;
    logic                      lsr_mask;
    logic                      stx_pad_o;
    logic [2:0]                tstate;
    logic [FIFO_COUNTER_W-1:0] tf_count;

    modport master (
        output lcr, tf_push, wb_dat_i, enable, tx_reset, lsr_mask,
        input  stx_pad_o, tstate, tf_count
    );

    modport slave (
        input  lcr, tf_push, wb_dat_i, enable, tx_reset, lsr_mask,
        output stx_pad_o, tstate, tf_count
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous TX FIFO with push/pop/flush and occupancy count
// Ports: clk, wb_rst_i (async, active-high), i_push, i_pop, i_flush, i_data,
// o_head (combinational head entry), o_count (occupancy), o_empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int COUNT_W = FIFO_COUNTER_W,
    parameter int WIDTH   = DATA_W
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [WIDTH-1:0]   i_data,
    output logic [WIDTH-1:0]   o_head,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == COUNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign w_do_push = i_push && !w_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + COUNT_W'(w_do_push) - COUNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - 16550-style serial transmitter: FIFO, framing FSM and shifter
// Ports: clk, wb_rst_i (async, active-high), bus (uart_tx_engine_if.slave):
// lcr/tf_push/wb_dat_i/enable/tx_reset/lsr_mask in, stx_pad_o/tstate/tf_count out.
module uart_tx_engine
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             wb_rst_i,
    uart_tx_engine_if.slave  bus
);
    tx_state_e               r_state;
    logic [4:0]              r_tick;
    logic [DATA_W-1:0]       r_shift;
    logic [2:0]              r_bits_left;
    logic                    r_parity;
    logic                    r_bit;
    logic                    r_stx;

    logic [FIFO_COUNTER_W-1:0] w_count;
    logic [DATA_W-1:0]         w_head;
    logic                      w_empty;
    logic                      w_pop;
    logic [2:0]                w_bits_m1;
    logic [DATA_W-1:0]         w_active;
    logic                      w_xor;
    logic                      w_par;
    logic [4:0]                w_stop_last;
    logic                      w_unused_bits;

    // lsr_mask and DLAB have no meaning on the transmit side.
    assign w_unused_bits = bus.lsr_mask ^ bus.lcr[7];

    assign w_pop = bus.enable && (r_state == S_POP_BYTE) && !w_empty;

    uart_tx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .COUNT_W (FIFO_COUNTER_W),
        .WIDTH   (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .i_push   (bus.tf_push),
        .i_pop    (w_pop),
        .i_flush  (bus.tx_reset),
        .i_data   (bus.wb_dat_i),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_empty  (w_empty)
    );

    // Word length minus one: 00->4 (5 bits) .. 11->7 (8 bits)
    assign w_bits_m1   = {1'b1, bus.lcr[LC_BITS+1:LC_BITS]};
    // Bits above the word length do not take part in parity
    assign w_active    = w_head & (8'hFF >> (3'd7 - w_bits_m1));
    assign w_xor       = ^w_active;
    assign w_par       = bus.lcr[LC_SP] ? ~bus.lcr[LC_EP]
                       : (bus.lcr[LC_EP] ? w_xor : ~w_xor);
    assign w_stop_last = stop_last_tick(bus.lcr[LC_SB], bus.lcr[LC_BITS+1:LC_BITS]);

    // r_bit is the line level the frame wants; r_stx is the registered pad
    // value one clk later with break forcing it low.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_parity    <= 1'b0;
            r_bit       <= 1'b1;
            r_stx       <= 1'b1;
        end else begin
            r_stx <= bus.lcr[LC_BC] ? 1'b0 : r_bit;
            if (bus.enable) begin
                case (r_state)
                    S_IDLE: begin
                        r_bit <= 1'b1;
                        if (w_count != '0)
                            r_state <= S_POP_BYTE;
                    end
                    S_POP_BYTE: begin
                        // A flush between IDLE and here leaves nothing to send.
                        if (w_empty) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_shift     <= w_head;
                            r_bits_left <= w_bits_m1;
                            r_parity    <= w_par;
                            r_tick      <= '0;
                            r_bit       <= 1'b0;
                            r_state     <= S_SEND_START;
                        end
                    end
                    S_SEND_START: begin
                        if (r_tick == 5'd15) begin
                            r_tick  <= '0;
                            r_bit   <= r_shift[0];
                            r_state <= S_SEND_BYTE;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_SEND_BYTE: begin
                        if (r_tick == 5'd15) begin
                            r_tick <= '0;
                            if (r_bits_left == '0) begin
                                if (bus.lcr[LC_PE]) begin
                                    r_bit   <= r_parity;
                                    r_state <= S_SEND_PARITY;
                                end else begin
                                    r_bit   <= 1'b1;
                                    r_state <= S_SEND_STOP;
                                end
                            end else begin
                                r_shift     <= r_shift >> 1;
                                r_bit       <= r_shift[1];
                                r_bits_left <= r_bits_left - 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_SEND_PARITY: begin
                        if (r_tick == 5'd15) begin
                            r_tick  <= '0;
                            r_bit   <= 1'b1;
                            r_state <= S_SEND_STOP;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_SEND_STOP: begin
                        if (r_tick >= w_stop_last) begin
                            r_tick  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    default: begin
                        r_tick  <= '0;
                        r_bit   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.stx_pad_o = r_stx;
    assign bus.tstate    = r_state;
    assign bus.tf_count  = w_count;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine
module tb_uart_tx_engine;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 clk = ~clk;

    uart_tx_engine_if bus();

    uart_tx_engine dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .bus      (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    logic       cap_stx [4096];
    logic [2:0] cap_st  [4096];
    int         ncap;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.tf_push  = 1'b1;
        bus.wb_dat_i = d;
        @(negedge clk);
        bus.tf_push  = 1'b0;
    endtask

    // Run with enable every clk until the transmitter is idle and empty.
    task automatic capture(input int budget);
        int quiet;
        bit seen;
        bit done;
        ncap = 0; quiet = 0; seen = 0; done = 0;
        bus.enable = 1'b1;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (ncap < 4096) begin
                cap_stx[ncap] = bus.stx_pad_o;
                cap_st[ncap]  = bus.tstate;
                ncap++;
            end
            if (bus.tstate != 3'd0) seen = 1;
            if (seen && bus.tstate == 3'd0 && bus.tf_count == '0) quiet++;
            else quiet = 0;
            if (quiet >= 4) done = 1;
        end
        bus.enable = 1'b0;
        chk("capture_done", done, 1);
    endtask

    // Receiver model: finds start bits in the captured line and samples each
    // bit at its middle, 16 ticks per bit.
    task automatic decode(input logic [7:0] lcr_v, input int nexp);
        int n, pe, stop_len, i, frames, stop_cycles, ones, base, fend;
        logic [7:0] got, expd, mask;
        logic exp_par;
        bit all_high;
        n = 5 + int'(lcr_v[1:0]);
        pe = int'(lcr_v[3]);
        stop_len = (lcr_v[2] == 1'b0) ? 16 : ((n == 5) ? 24 : 32);
        mask = 8'((1 << n) - 1);
        frames = 0; stop_cycles = 0; i = 0;
        for (int k = 0; k < ncap; k++)
            if (cap_st[k] == 3'd5) stop_cycles++;
        while (i < ncap) begin
            if (cap_stx[i] == 1'b0) begin
                fend = i + 16 * (n + 1 + pe) + stop_len;
                if (fend > ncap) begin
                    chk("frame_truncated", fend, ncap);
                    break;
                end
                chk("start_bit", cap_stx[i + 8], 0);
                got = '0;
                for (int k = 0; k < n; k++)
                    got[k] = cap_stx[i + 8 + 16 * (k + 1)];
                expd = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                chk("frame_data", got, expd & mask);
                if (pe != 0) begin
                    ones = $countones(expd & mask);
                    if (lcr_v[5]) exp_par = ~lcr_v[4];
                    else if (lcr_v[4]) exp_par = logic'(ones % 2);
                    else exp_par = logic'(1 - ones % 2);
                    chk("parity_bit", cap_stx[i + 8 + 16 * (n + 1)], exp_par);
                end
                base = i + 16 * (n + 1 + pe);
                all_high = 1;
                for (int k = base; k < fend; k++)
                    if (cap_stx[k] !== 1'b1) all_high = 0;
                chk("stop_high", all_high, 1);
                frames++;
                i = fend;
            end else begin
                i++;
            end
        end
        chk("frame_count", frames, nexp);
        chk("stop_len", stop_cycles, stop_len * nexp);
        exp_q.delete();
    endtask

    task automatic run_frames(input logic [7:0] lcr_v, input int nb, input logic [7:0] first);
        logic [7:0] d;
        bus.lcr = lcr_v;
        bus.enable = 1'b0;
        for (int k = 0; k < nb; k++) begin
            d = (k == 0) ? first : 8'($urandom);
            exp_q.push_back(d);
            push(d);
        end
        chk("count_after_push", bus.tf_count, nb);
        capture(3000);
        decode(lcr_v, nb);
        chk("count_drained", bus.tf_count, 0);
    endtask

    initial begin
        logic [7:0] d;
        bit done;
        bus.lcr = 8'h03; bus.tf_push = 0; bus.wb_dat_i = 0; bus.enable = 0;
        bus.tx_reset = 0; bus.lsr_mask = 0;
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        chk("rst_stx", bus.stx_pad_o, 1);
        chk("rst_tstate", bus.tstate, 0);
        chk("rst_count", bus.tf_count, 0);

        bus.enable = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_stx", bus.stx_pad_o, 1);
        chk("idle_tstate", bus.tstate, 0);
        chk("idle_count", bus.tf_count, 0);
        bus.enable = 1'b0;

        run_frames(8'h03, 1, 8'h55);
        run_frames(8'h1B, 1, 8'h07);
        run_frames(8'h0B, 1, 8'h07);
        run_frames(8'h2B, 1, 8'h07);
        run_frames(8'h04, 1, 8'hFF);
        run_frames(8'h07, 1, 8'($urandom));
        for (int r = 0; r < 6; r++)
            run_frames(8'($urandom_range(0, 63)), int'($urandom_range(1, 3)), 8'($urandom));

        // FIFO saturation and flush
        bus.enable = 1'b0;
        for (int k = 0; k < 17; k++) push(8'($urandom));
        chk("fifo_full", bus.tf_count, 16);
        bus.tx_reset = 1'b1;
        @(negedge clk);
        bus.tx_reset = 1'b0;
        chk("flush_count", bus.tf_count, 0);
        push(8'h11);
        bus.tx_reset = 1'b1; bus.tf_push = 1'b1; bus.wb_dat_i = 8'h22;
        @(negedge clk);
        bus.tx_reset = 1'b0; bus.tf_push = 1'b0;
        chk("flush_beats_push", bus.tf_count, 0);

        // Push and pop in the same cycle
        bus.lcr = 8'h03;
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            push(d);
        end
        chk("pp_pre_count", bus.tf_count, 3);
        bus.enable = 1'b1;
        @(negedge clk);
        d = 8'($urandom);
        exp_q.push_back(d);
        bus.tf_push = 1'b1; bus.wb_dat_i = d;
        @(negedge clk);
        bus.tf_push = 1'b0; bus.enable = 1'b0;
        chk("pp_count", bus.tf_count, 3);
        chk("pp_tstate", bus.tstate, 2);
        capture(4000);
        decode(8'h03, 4);

        // Break mid-frame
        bus.lcr = 8'h03;
        push(8'($urandom));
        bus.enable = 1'b1;
        repeat (40) @(negedge clk);
        bus.lcr = 8'h43;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("break_low", bus.stx_pad_o, 0);
        end
        bus.lcr = 8'h03;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (bus.tstate == 3'd0 && bus.tf_count == '0) done = 1;
        end
        chk("break_frame_done", done, 1);
        @(negedge clk);
        chk("break_stx_idle", bus.stx_pad_o, 1);

        // Asynchronous reset mid-frame
        push(8'h00);
        repeat (60) @(negedge clk);
        push(8'hA5);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("async_rst_stx", bus.stx_pad_o, 1);
        chk("async_rst_tstate", bus.tstate, 0);
        chk("async_rst_count", bus.tf_count, 0);
        @(negedge clk);
        wb_rst_i = 1'b0;
        bus.enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
